pc_gen: RTL
===========

Name: pc_gen

Overview:
- Registered program-counter generator for the RISC-V fetch stage. Successor to the combinational PC select.
- Holds the architectural fetch PC and advances it sequentially under a valid/ready handshake with fetch.
- Arbitrates prioritised redirects (trap, return, jump/branch) and detects misaligned targets.
- Supports debug halt/resume. Parametrised in PC width, reset vector and trap vector.

Parameters:
- XLEN, 32, PC width in bits.
- RESET_VEC, 32'h0000_0000, PC value presented first after reset.
- TRAP_VEC, 32'h0000_0100, target for traps and misaligned-target exceptions.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- pc  out  XLEN  current fetch PC.
- pc_valid  out  1  pc is a valid fetch request.
- pc_ready  in  1  fetch accepts pc this cycle.
- redir_valid  in  1  redirect request.
- redir_sel  in  2  redirect type: 0 jump/branch, 1 trap, 2 return (epc), 3 reserved (ignored).
- jmp_addr  in  XLEN  jump/branch target.
- epc  in  XLEN  return target.
- halt_req  in  1  debug halt request.
- resume_req  in  1  debug resume request.
- halted  out  1  block is in HALT.
- misalign  out  1  one-cycle pulse: a jump/return target was misaligned.
- misalign_addr  out  XLEN  offending target, captured on the misalign pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_VEC, pc_valid=0, halted=0, misalign=0, misalign_addr=0.
  - State=BOOT.
- BOOT: on the first clock edge with reset=1, go to RUN and set pc_valid=1. pc stays RESET_VEC.
- RUN, evaluated at each edge in priority order:
  1. redir_valid with sel 1 (trap): pc<=TRAP_VEC.
  2. redir_valid with sel 2 (return): pc<=epc.
  3. redir_valid with sel 0 (jump/branch): pc<=jmp_addr.
  4. pc_valid & pc_ready: pc<=pc+4.
  5. Otherwise pc holds.
- Redirect rules:
  - A redirect is taken regardless of pc_ready; the un-accepted pc is discarded.
  - Redirect latency is 1 cycle: target appears on pc in the next cycle with pc_valid=1.
  - redir_sel 3 is treated as no redirect.
- Misalignment:
  - Target is misaligned when target[1:0]!=0 (jump or return only).
  - Instead of the target: pc<=TRAP_VEC, misalign=1 for exactly one cycle, misalign_addr<=target.
  - misalign_addr holds its value until the next misalign event.
- Arithmetic: pc+4 is modulo 2^XLEN. pc=2^XLEN-4 advances to 0; no flag is raised.
- Halt:
  - halt_req in RUN: next state HALT, pc_valid=0, halted=1, pc holds.
  - A redirect in the same cycle as halt_req is applied first, so pc holds the redirect target while halted.
  - In HALT: redirects update pc (debug may write the PC through jump). misalign behaves as in RUN. pc_ready is ignored.
  - resume_req in HALT: next state RUN, pc_valid=1, halted=0. halt_req and resume_req together in HALT: stay in HALT.
- pc_valid=1 stall: pc must stay stable until it is accepted or redirected.
- Reset asserted mid-operation forces the reset values immediately; pending redirects and halts are lost.

Optional Feature:
- Macro: PC_GEN_COMPRESSED_EN.
- Defined:
  - Adds input is_compressed (1 bit, sampled with pc_ready).
  - Sequential advance is pc+2 when is_compressed=1, else pc+4.
  - Misalignment check uses target[0] only. RESET_VEC and TRAP_VEC must be 2-byte aligned.
- Undefined: no is_compressed port, increment is always 4, misalignment check uses target[1:0].

Test Plan:
- Release reset (RESET_VEC=0) with pc_ready=1 for 3 cycles:
  - Expected: cycle 1 pc_valid=1, pc=0; then pc=4, then pc=8.
- pc_ready=0 for 3 cycles at pc=0x10:
  - Expected: pc held at 0x10, pc_valid=1.
- Then redir_valid with sel=0, jmp_addr=0x200, pc_ready=0:
  - Expected: next cycle pc=0x200.
- Same cycle: redir_valid with sel=1 and a concurrent jump to 0x400:
  - Expected: next pc=TRAP_VEC=0x100.
- Return with epc=0x80 in the following cycle:
  - Expected: pc=0x80.
- Jump to 0x202:
  - Expected: next pc=0x100, misalign high for exactly 1 cycle, misalign_addr=0x202.
- With the macro defined, jump to 0x202:
  - Expected: pc=0x202, no misalign; then is_compressed=1 with pc_ready=1 gives pc=0x204.
- halt_req at pc=0x40:
  - Expected: halted=1, pc_valid=0, pc=0x40.
- While halted, jump to 0x300, then resume_req:
  - Expected: pc_valid=1, pc=0x300.
- pc=0xFFFF_FFFC with pc_ready=1:
  - Expected: next pc=0.
- Assert reset mid-stream:
  - Expected: pc=RESET_VEC and pc_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - registered fetch PC generator with prioritised redirects, misalign trap and debug halt (optional PC_GEN_COMPRESSED_EN)
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100)
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    input  logic            pc_ready,
    input  logic            redir_valid,
    input  logic [1:0]      redir_sel,
    input  logic [XLEN-1:0] jmp_addr,
    input  logic [XLEN-1:0] epc,
    input  logic            halt_req,
    input  logic            resume_req,
`ifdef PC_GEN_COMPRESSED_EN
    input  logic            is_compressed,
`endif
    output logic            halted,
    output logic            misalign,
    output logic [XLEN-1:0] misalign_addr
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [1:0] SEL_JUMP   = 2'd0;
    localparam logic [1:0] SEL_TRAP   = 2'd1;
    localparam logic [1:0] SEL_RETURN = 2'd2;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] incr;
    logic [XLEN-1:0] maddr_nxt;
    logic            mis_nxt;
    logic            take_redir;
    logic            take_trap;
    logic            target_bad;

    // Redirect decode: pick the target and decide whether it is a trap or a checked jump/return
    always_comb begin
        target     = jmp_addr;
        take_redir = 1'b0;
        take_trap  = 1'b0;
        if (redir_valid) begin
            case (redir_sel)
                SEL_TRAP: begin
                    take_redir = 1'b1;
                    take_trap  = 1'b1;
                end
                SEL_RETURN: begin
                    take_redir = 1'b1;
                    target     = epc;
                end
                SEL_JUMP: begin
                    take_redir = 1'b1;
                    target     = jmp_addr;
                end
                default: ;
            endcase
        end
`ifdef PC_GEN_COMPRESSED_EN
        target_bad = target[0];
        incr       = is_compressed ? XLEN'(2) : XLEN'(4);
`else
        target_bad = |target[1:0];
        incr       = XLEN'(4);
`endif
    end

    // Next-state and next-PC selection; redirects win over sequential advance and apply in HALT too
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        mis_nxt   = 1'b0;
        maddr_nxt = misalign_addr;
        case (state)
            BOOT: state_nxt = RUN;
            RUN, HALT: begin
                if (take_redir) begin
                    if (take_trap) begin
                        pc_nxt = TRAP_VEC;
                    end else if (target_bad) begin
                        pc_nxt    = TRAP_VEC;
                        mis_nxt   = 1'b1;
                        maddr_nxt = target;
                    end else begin
                        pc_nxt = target;
                    end
                end else if (state == RUN && pc_ready && !halt_req) begin
                    // wraps modulo 2^XLEN by construction
                    pc_nxt = pc + incr;
                end
                if (state == RUN && halt_req) begin
                    state_nxt = HALT;
                end else if (state == HALT && resume_req && !halt_req) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    // State, PC and misalign capture registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= BOOT;
            pc            <= RESET_VEC;
            misalign      <= 1'b0;
            misalign_addr <= '0;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            misalign      <= mis_nxt;
            misalign_addr <= maddr_nxt;
        end
    end

    assign pc_valid = (state == RUN);
    assign halted   = (state == HALT);

endmodule
